// File: rtl/wsp_ctrl.sv
// Wrapper serial port controller: WIR shift/capture/update, WBY bypass bit,
// instruction decode fanned to every boundary cell, WBR shift counter.
module wsp_ctrl #(
    parameter int WIR_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             select_wir,
    input  logic             shift_wr,
    input  logic             capture_wr,
    input  logic             update_wr,
    input  logic             transfer_wr,
    input  logic             wsi,
    input  logic             wbr_so,
    output logic             wso,
    output logic             shift,
    output logic             capture,
    output logic             transfer,
    output logic             update,
    output logic             mode,
    output logic             safe,
    output logic             io_face,
    output logic [WIR_W-1:0] instr,
    output logic [CNT_W-1:0] wbr_cnt,
    output logic             proto_err
);

    localparam logic [WIR_W-1:0] WS_EXTEST  = WIR_W'(1);
    localparam logic [WIR_W-1:0] WS_INTEST  = WIR_W'(2);
    localparam logic [WIR_W-1:0] WS_SAFE    = WIR_W'(3);
    localparam logic [WIR_W-1:0] WS_PRELOAD = WIR_W'(4);
    localparam logic [WIR_W-1:0] WIR_CAPTURE = WIR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIR_W-1:0] wir_sr;
    logic             wby;
    logic [2:0]       n_strobe;
    logic             legal;
    logic             wbr_sel;
    logic             wbr_act;
    logic             wby_act;

    assign n_strobe = {2'b00, shift_wr} + {2'b00, capture_wr}
                    + {2'b00, update_wr} + {2'b00, transfer_wr};
    assign legal    = (n_strobe <= 3'd1);

    // Decode is driven by the registered instr only, so a new instruction
    // reaches the cells the cycle after the update strobe.
    always_comb begin
        wbr_sel = 1'b0;
        mode    = 1'b0;
        safe    = 1'b0;
        io_face = 1'b0;
        case (instr)
            WS_EXTEST: begin
                wbr_sel = 1'b1;
                mode    = 1'b1;
                io_face = 1'b1;
            end
            WS_INTEST: begin
                wbr_sel = 1'b1;
                mode    = 1'b1;
            end
            WS_SAFE: begin
                mode = 1'b1;
                safe = 1'b1;
            end
            WS_PRELOAD: wbr_sel = 1'b1;
            default: ;
        endcase
    end

    assign wbr_act = !select_wir && wbr_sel && legal;
    assign wby_act = !select_wir && !wbr_sel && legal;

    assign shift    = wbr_act & shift_wr;
    assign capture  = wbr_act & capture_wr;
    assign update   = wbr_act & update_wr;
    assign transfer = wbr_act & transfer_wr;

    assign wso = select_wir ? wir_sr[0] : (wbr_sel ? wbr_so : wby);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wir_sr <= '0;
            instr  <= '0;
        end else if (select_wir && legal) begin
            if (shift_wr)
                wir_sr <= {wsi, wir_sr[WIR_W-1:1]};
            else if (capture_wr)
                wir_sr <= WIR_CAPTURE;
            else if (update_wr)
                instr <= wir_sr;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            wby <= 1'b0;
        else if (wby_act) begin
            if (shift_wr)
                wby <= wsi;
            else if (capture_wr)
                wby <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            wbr_cnt <= '0;
        else if (wbr_act) begin
            if (capture_wr)
                wbr_cnt <= '0;
            else if (shift_wr && wbr_cnt != CNT_MAX)
                wbr_cnt <= wbr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            proto_err <= 1'b0;
        else if (!legal)
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_wsp_ctrl.sv
// Self-checking bench for wsp_ctrl: directed scenarios plus randomized legal
// traffic compared against an instruction-level reference model.
module tb_wsp_ctrl;
    localparam int WIR_W = 3;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic arst_n;
    logic select_wir, shift_wr, capture_wr, update_wr, transfer_wr, wsi, wbr_so;
    logic wso, shift, capture, transfer, update, mode, safe, io_face, proto_err;
    logic [WIR_W-1:0] instr;
    logic [CNT_W-1:0] wbr_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_wir, m_instr, m_wby, m_cnt, m_err;
    int mode_tab[5]  = '{0, 1, 1, 1, 0};
    int safe_tab[5]  = '{0, 0, 0, 1, 0};
    int face_tab[5]  = '{0, 1, 0, 0, 0};
    int wbr_tab[5]   = '{0, 1, 1, 0, 1};

    wsp_ctrl #(.WIR_W(WIR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .select_wir(select_wir), .shift_wr(shift_wr),
        .capture_wr(capture_wr), .update_wr(update_wr), .transfer_wr(transfer_wr),
        .wsi(wsi), .wbr_so(wbr_so), .wso(wso), .shift(shift), .capture(capture),
        .transfer(transfer), .update(update), .mode(mode), .safe(safe),
        .io_face(io_face), .instr(instr), .wbr_cnt(wbr_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int dec();
        return (m_instr <= 4) ? m_instr : 0;
    endfunction

    function automatic bit legal_now();
        return (int'(shift_wr) + int'(capture_wr) + int'(update_wr) + int'(transfer_wr)) <= 1;
    endfunction

    function automatic logic exp_wso();
        if (select_wir) return logic'(m_wir % 2);
        if (wbr_tab[dec()] != 0) return wbr_so;
        return logic'(m_wby);
    endfunction

    // {wso, shift, capture, update, transfer, mode, safe, io_face}
    function automatic logic [7:0] exp_outs();
        bit en;
        en = !select_wir && (wbr_tab[dec()] != 0) && legal_now();
        return {exp_wso(), en & shift_wr, en & capture_wr, en & update_wr, en & transfer_wr,
                logic'(mode_tab[dec()]), logic'(safe_tab[dec()]), logic'(face_tab[dec()])};
    endfunction

    function automatic logic [7:0] act_outs();
        return {wso, shift, capture, update, transfer, mode, safe, io_face};
    endfunction

    task automatic model_reset();
        m_wir = 0; m_instr = 0; m_wby = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_step();
        if (!legal_now()) begin
            m_err = 1;
        end else if (select_wir) begin
            if (shift_wr)        m_wir = (m_wir >> 1) + (int'(wsi) << (WIR_W - 1));
            else if (capture_wr) m_wir = 1;
            else if (update_wr)  m_instr = m_wir;
        end else if (wbr_tab[dec()] != 0) begin
            if (capture_wr)    m_cnt = 0;
            else if (shift_wr) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
            if (shift_wr)        m_wby = int'(wsi);
            else if (capture_wr) m_wby = 0;
        end
    endtask

    task automatic drive(input bit sel, input bit sh, input bit cap, input bit upd,
                         input bit tr, input bit w, input bit so);
        select_wir = sel; shift_wr = sh; capture_wr = cap; update_wr = upd;
        transfer_wr = tr; wsi = w; wbr_so = so;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic load_wir(input int code);
        for (int i = 0; i < WIR_W; i++) begin
            drive(1, 1, 0, 0, 0, bit'((code >> i) & 1), 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (act_outs() !== 8'h00) begin
            errors++; $display("FAIL reset_outs: got %b expected %b", act_outs(), 8'h00);
        end
        checks++;
        if (instr !== 3'd0 || wbr_cnt !== 8'd0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got instr=%0d cnt=%0d err=%0d expected 0/0/0",
                               instr, wbr_cnt, proto_err);
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wir_integrity();
        bit pat[3] = '{1'b1, 1'b0, 1'b0};
        bit exp[3] = '{1'b1, 1'b0, 1'b0};
        drive(1, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, pat[i], 0);
            checks++;
            if (wso !== exp[i]) begin
                errors++; $display("FAIL wir_wso_%0d: got %b expected %b", i, wso, exp[i]);
            end
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        checks++;
        if (wso !== 1'b1) begin
            errors++; $display("FAIL wir_end_lsb: got %b expected 1", wso);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (instr !== 3'b001) begin
            errors++; $display("FAIL wir_end_value: got %b expected 001", instr);
        end
    endtask

    task automatic test_extest();
        bit so;
        load_wir(0);
        for (int i = 0; i < WIR_W; i++) begin
            drive(1, 1, 0, 0, 0, bit'((1 >> i) & 1), 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 0);
        checks++;
        if (mode !== 1'b0) begin
            errors++; $display("FAIL extest_mode_early: got %b expected 0", mode);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({instr, mode, io_face, safe} !== {3'b001, 3'b110}) begin
            errors++; $display("FAIL extest_decode: got instr=%b m/f/s=%b%b%b expected 001 110",
                               instr, mode, io_face, safe);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            so = bit'($urandom_range(0, 1));
            drive(0, 1, 0, 0, 0, bit'($urandom_range(0, 1)), so);
            checks++;
            if (shift !== 1'b1 || wso !== so) begin
                errors++; $display("FAIL extest_shift_%0d: got shift=%b wso=%b expected 1 %b",
                                   i, shift, wso, so);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wbr_cnt !== 8'd5) begin
            errors++; $display("FAIL extest_cnt: got %0d expected 5", wbr_cnt);
        end
    endtask

    task automatic test_safe();
        load_wir(3);
        checks++;
        if ({mode, safe, io_face} !== 3'b110) begin
            errors++; $display("FAIL safe_decode: got %b%b%b expected 110", mode, safe, io_face);
        end
        drive(0, 1, 0, 0, 0, 1, 0);
        checks++;
        if (shift !== 1'b0) begin
            errors++; $display("FAIL safe_shift_out: got %b expected 0", shift);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wso !== 1'b1) begin
            errors++; $display("FAIL safe_wby: got %b expected 1", wso);
        end
    endtask

    task automatic test_bad_code();
        load_wir(7);
        checks++;
        if (instr !== 3'b111 || mode !== 1'b0) begin
            errors++; $display("FAIL bad_code_decode: got instr=%b mode=%b expected 111 0", instr, mode);
        end
        drive(0, 0, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (wso !== 1'b0) begin
            errors++; $display("FAIL bad_code_wby_cap: got %b expected 0", wso);
        end
        drive(0, 1, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wso !== 1'b1) begin
            errors++; $display("FAIL bad_code_wby_shift: got %b expected 1", wso);
        end
    endtask

    task automatic test_saturation();
        load_wir(4);
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < CNT_MAX + 10; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (int'(wbr_cnt) !== CNT_MAX) begin
            errors++; $display("FAIL cnt_saturate: got %0d expected %0d", wbr_cnt, CNT_MAX);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wbr_cnt !== 8'd0) begin
            errors++; $display("FAIL cnt_clear: got %0d expected 0", wbr_cnt);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 4));
            drive(bit'($urandom_range(0, 3) == 0), r == 1, r == 2, r == 3, r == 4,
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            checks++;
            if (act_outs() !== exp_outs()) begin
                errors++; $display("FAIL rand_outs_%0d: got %b expected %b", i, act_outs(), exp_outs());
            end
            checks++;
            if (int'(instr) !== m_instr || int'(wbr_cnt) !== m_cnt || int'(proto_err) !== m_err) begin
                errors++; $display("FAIL rand_regs_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                   i, instr, wbr_cnt, proto_err, m_instr, m_cnt, m_err);
            end
            tick();
        end
    endtask

    task automatic test_proto_err();
        logic w0;
        load_wir(1);
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 0, 0, 1, 0);
        checks++;
        if ({shift, capture, update, transfer} !== 4'b0000) begin
            errors++; $display("FAIL proto_cells: got %b expected 0000",
                               {shift, capture, update, transfer});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (proto_err !== 1'b1 || wbr_cnt !== 8'd2) begin
            errors++; $display("FAIL proto_set: got err=%b cnt=%0d expected 1 2", proto_err, wbr_cnt);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        w0 = wso;
        drive(1, 1, 0, 1, 0, ~w0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wso !== w0 || instr !== 3'b001) begin
            errors++; $display("FAIL proto_wir_hold: got wso=%b instr=%b expected %b 001", wso, instr, w0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err);
        end
    endtask

    task automatic test_async_reset();
        load_wir(1);
        drive(0, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (wbr_cnt !== 8'd3) begin
            errors++; $display("FAIL areset_pre_cnt: got %0d expected 3", wbr_cnt);
        end
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (wbr_cnt !== 8'd0 || instr !== 3'd0 || proto_err !== 1'b0 || mode !== 1'b0) begin
            errors++; $display("FAIL areset_async: got cnt=%0d instr=%0d err=%b mode=%b expected 0 0 0 0",
                               wbr_cnt, instr, proto_err, mode);
        end
        @(negedge clk);
        arst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (wso !== 1'b0) begin
            errors++; $display("FAIL areset_wir_cleared: got %b expected 0", wso);
        end
    endtask

    initial begin
        select_wir = 0; shift_wr = 0; capture_wr = 0; update_wr = 0;
        transfer_wr = 0; wsi = 0; wbr_so = 0;
        test_reset();
        test_wir_integrity();
        test_extest();
        test_safe();
        test_bad_code();
        test_saturation();
        test_random();
        test_proto_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
